// File: rtl/rr_merge2.sv
// ============================================================================
// Module   : rr_merge2
// Function : two-input round-robin stream merger with one registered slot
//            and a per-input accept counter for each channel.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_merge2 #(
    parameter int DW   = 8,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in0_valid,
    output logic            in0_ready,
    input  logic [DW-1:0]   in0_data,
    input  logic            in1_valid,
    output logic            in1_ready,
    input  logic [DW-1:0]   in1_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_src,
    output logic [CNTW-1:0] cnt0,
    output logic [CNTW-1:0] cnt1
);

    localparam logic [0:0] c_S_EMPTY = 1'b0;
    localparam logic [0:0] c_S_FULL  = 1'b1;
    localparam logic [CNTW-1:0] c_CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic            w_load_en;
    logic            w_gnt_vld;
    logic            w_gnt_sel;
    logic            r_ptr;
    logic [DW-1:0]   r_data;
    logic            r_src;
    logic [CNTW-1:0] r_cnt0;
    logic [CNTW-1:0] r_cnt1;

    assign w_load_en = (r_state == c_S_EMPTY) | out_ready;

    // Readys are gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_sel = 1'b0;
        if (rst_n && w_load_en) begin
            if (in0_valid && in1_valid) begin
                w_gnt_vld = 1'b1;
                w_gnt_sel = ~r_ptr;
            end else if (in0_valid) begin
                w_gnt_vld = 1'b1;
                w_gnt_sel = 1'b0;
            end else if (in1_valid) begin
                w_gnt_vld = 1'b1;
                w_gnt_sel = 1'b1;
            end
        end
    end

    assign in0_ready = w_gnt_vld & ~w_gnt_sel;
    assign in1_ready = w_gnt_vld &  w_gnt_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_gnt_vld) begin
            w_state_nxt = c_S_FULL;
        end else if ((r_state == c_S_FULL) && out_ready) begin
            w_state_nxt = c_S_EMPTY;
        end
    end

    always_comb begin
        out_valid = (r_state == c_S_FULL);
    end

    // A granted input is always valid, so the grant itself marks the accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= 1'b1;
            r_data <= '0;
            r_src  <= 1'b0;
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_gnt_vld) begin
            r_ptr  <= w_gnt_sel;
            r_src  <= w_gnt_sel;
            r_data <= w_gnt_sel ? in1_data : in0_data;
            if (w_gnt_sel) begin
                r_cnt1 <= r_cnt1 + c_CNT_ONE;
            end else begin
                r_cnt0 <= r_cnt0 + c_CNT_ONE;
            end
        end
    end

    assign out_data = r_data;
    assign out_src  = r_src;
    assign cnt0     = r_cnt0;
    assign cnt1     = r_cnt1;

endmodule

`default_nettype wire
